// File: rtl/full_subtractor_pkg.sv
// Shared definitions for the registered full subtractor.
// fs_ref is an arithmetic reference ({bo, d} = a - b - c) for scoreboards;
// the RTL itself uses the bit-cell chain in fs_bit.
package full_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 1;

  // Returns {bo, d} in the low width+1 bits for operands up to 32 bits wide.
  function automatic logic [32:0] fs_ref(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic        c,
                                         input int          width);
    logic [63:0] mask_w;
    logic [63:0] mask_r;
    logic [63:0] diff;
    mask_w = (64'd1 << width) - 64'd1;
    mask_r = (64'd1 << (width + 1)) - 64'd1;
    diff   = ({32'd0, a} & mask_w) - ({32'd0, b} & mask_w) - {63'd0, c};
    return 33'(diff & mask_r);
  endfunction

endpackage

// File: rtl/full_subtractor_fs_bit.sv
// Combinational 1-bit full subtractor cell: d = a ^ b ^ bin, borrow-out when
// the minuend bit cannot cover the subtrahend bit plus the incoming borrow.
module fs_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/full_subtractor.sv
// Registered ripple-borrow subtractor: {bo, d} = a - b - c, one cycle latency.
// Handshake: a result is accepted on every rising edge where in_valid=1
// (no backpressure); out_valid is high for exactly the cycle after such an
// edge, and d/bo (and ovf) hold their last result while out_valid is low.
// Optional signed-overflow output ovf is enabled by FULL_SUBTRACTOR_OVF_EN.
module full_subtractor
  import full_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic             out_valid,
  output logic [WIDTH-1:0] d,
  output logic             bo
`ifdef FULL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Borrow chain: br[0] is the borrow-in, br[WIDTH] the borrow-out.
  logic [WIDTH:0]   br;
  logic [WIDTH-1:0] diff;

  assign br[0] = c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fs_bit u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .bin  (br[i]),
      .d    (diff[i]),
      .bout (br[i+1])
    );
  end

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bo_q, bo_d;

  // Next-state: capture a new result on valid input, otherwise hold data.
  always_comb begin
    out_valid_d = 1'b0;
    d_d         = d_q;
    bo_d        = bo_q;
    if (in_valid) begin
      out_valid_d = 1'b1;
      d_d         = diff;
      bo_d        = br[WIDTH];
    end
  end

  // Output registers with synchronous reset that wins over in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      d_q         <= '0;
      bo_q        <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      d_q         <= d_d;
      bo_q        <= bo_d;
    end
  end

  assign out_valid = out_valid_q;
  assign d         = d_q;
  assign bo        = bo_q;

`ifdef FULL_SUBTRACTOR_OVF_EN
  logic ovf_q, ovf_d;

  // Signed overflow: carries into and out of the sign bit disagree.
  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) begin
      ovf_d = br[WIDTH] ^ br[WIDTH-1];
    end
  end

  // Overflow register, same timing and reset as d.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_full_subtractor.sv
// Bench for full_subtractor: drives a WIDTH=1 and a WIDTH=8 instance side by
// side, pushes expected {ovf, bo, d} when a valid operand set is driven and
// pops it when the result appears one cycle later.
module tb_full_subtractor;
  import full_subtractor_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       iv1, a1, b1, c1;
  logic       ov1, d1, bo1;
  logic       iv8, c8;
  logic [7:0] a8, b8;
  logic       ov8, bo8;
  logic [7:0] d8;
`ifdef FULL_SUBTRACTOR_OVF_EN
  logic       ovf1, ovf8;
`endif

  full_subtractor #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv1),
    .a         (a1),
    .b         (b1),
    .c         (c1),
    .out_valid (ov1),
    .d         (d1),
    .bo        (bo1)
`ifdef FULL_SUBTRACTOR_OVF_EN
    ,
    .ovf       (ovf1)
`endif
  );

  full_subtractor #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv8),
    .a         (a8),
    .b         (b8),
    .c         (c8),
    .out_valid (ov8),
    .d         (d8),
    .bo        (bo8)
`ifdef FULL_SUBTRACTOR_OVF_EN
    ,
    .ovf       (ovf8)
`endif
  );

  // ---------------- scoreboard ----------------
  // Expected words are {ovf, bo, d}.
  logic [2:0] exp1_q[$];
  logic [9:0] exp8_q[$];
  logic [2:0] pend1, hold1;
  logic [9:0] pend8, hold8;
  int         total = 0;
  int         bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] model1(input logic a, input logic b, input logic c);
    logic [32:0] r;
    int          s;
    r = fs_ref({31'd0, a}, {31'd0, b}, c, 1);
    s = (a ? -1 : 0) - (b ? -1 : 0) - (c ? 1 : 0);
    return {(s < -1) || (s > 0), r[1:0]};
  endfunction

  function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [32:0] r;
    int          s;
    r = fs_ref({24'd0, a}, {24'd0, b}, c, 8);
    s = int'($signed(a)) - int'($signed(b)) - (c ? 1 : 0);
    return {(s < -128) || (s > 127), r[8:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set1(input logic v, input logic a, input logic b, input logic c,
                      input logic [2:0] e);
    iv1 = v; a1 = a; b1 = b; c1 = c; pend1 = e;
  endtask

  task automatic set8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [9:0] e);
    iv8 = v; a8 = a; b8 = b; c8 = c; pend8 = e;
  endtask

  // One clock: enqueue what was driven, then check the registered outputs.
  task automatic cycle();
    logic v1, v8;
    v1 = iv1 && !rst;
    v8 = iv8 && !rst;
    if (v1) exp1_q.push_back(pend1);
    if (v8) exp8_q.push_back(pend8);
    @(posedge clk);
    #1;
    if (rst) begin
      hold1 = '0;
      hold8 = '0;
    end else begin
      if (v1) hold1 = exp1_q.pop_front();
      if (v8) hold8 = exp8_q.pop_front();
    end
    check("w1_valid", 32'(ov1), 32'(v1));
    check("w1_bo_d", 32'({bo1, d1}), 32'(hold1[1:0]));
    check("w8_valid", 32'(ov8), 32'(v8));
    check("w8_bo_d", 32'({bo8, d8}), 32'(hold8[8:0]));
`ifdef FULL_SUBTRACTOR_OVF_EN
    check("w1_ovf", 32'(ovf1), 32'(hold1[2]));
    check("w8_ovf", 32'(ovf8), 32'(hold8[9]));
`endif
    iv1 = 1'b0;
    iv8 = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [2:0] tbl1[8];
  logic [2:0] idx;

  initial begin
    // Exhaustive WIDTH=1 expectations, {ovf, bo, d}, for abc = 000..111.
    tbl1[0] = 3'b000; tbl1[1] = 3'b011; tbl1[2] = 3'b111; tbl1[3] = 3'b010;
    tbl1[4] = 3'b001; tbl1[5] = 3'b100; tbl1[6] = 3'b000; tbl1[7] = 3'b011;
    hold1 = '0;
    hold8 = '0;

    // Reset overrides a valid input; outputs stay zero while rst is held.
    rst = 1'b1;
    set1(1'b1, 1'b1, 1'b0, 1'b0, 3'b001);
    set8(1'b1, 8'h01, 8'h00, 1'b0, 10'h001);
    cycle();
    set1(1'b1, 1'b1, 1'b0, 1'b0, 3'b001);
    set8(1'b1, 8'h01, 8'h00, 1'b0, 10'h001);
    cycle();
    rst = 1'b0;
    cycle();

    // WIDTH=1 exhaustive, back-to-back.
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      set1(1'b1, idx[2], idx[1], idx[0], tbl1[i]);
      cycle();
    end

    // WIDTH=8 wrap-around and full borrow.
    set8(1'b1, 8'h00, 8'h00, 1'b1, {1'b0, 1'b1, 8'hFF}); cycle();
    set8(1'b1, 8'h00, 8'hFF, 1'b1, {1'b0, 1'b1, 8'h00}); cycle();

    // Normal back-to-back pair.
    set8(1'b1, 8'h50, 8'h20, 1'b0, {1'b0, 1'b0, 8'h30}); cycle();
    set8(1'b1, 8'h20, 8'h50, 1'b0, {1'b0, 1'b1, 8'hD0}); cycle();

    // Signed overflow corners.
    set8(1'b1, 8'h80, 8'h01, 1'b0, {1'b1, 1'b0, 8'h7F}); cycle();
    set8(1'b1, 8'h7F, 8'hFF, 1'b0, {1'b1, 1'b1, 8'h80}); cycle();
    set8(1'b1, 8'h10, 8'h01, 1'b0, {1'b0, 1'b0, 8'h0F}); cycle();

    // Hold: three idle cycles with random operands must not disturb d/bo.
    for (int i = 0; i < 3; i++) begin
      set1(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'b000);
      set8(1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 10'h000);
      cycle();
    end

    // Random valid stream with occasional idle cycles.
    for (int i = 0; i < 40; i++) begin
      logic       ra1, rb1, rc1, rc8, rv1, rv8;
      logic [7:0] ra8, rb8;
      ra1 = 1'($urandom_range(0, 1)); rb1 = 1'($urandom_range(0, 1)); rc1 = 1'($urandom_range(0, 1));
      ra8 = 8'($urandom_range(0, 255)); rb8 = 8'($urandom_range(0, 255)); rc8 = 1'($urandom_range(0, 1));
      rv1 = ($urandom_range(0, 3) != 0);
      rv8 = ($urandom_range(0, 3) != 0);
      set1(rv1, ra1, rb1, rc1, model1(ra1, rb1, rc1));
      set8(rv8, ra8, rb8, rc8, model8(ra8, rb8, rc8));
      cycle();
    end

    // Mid-stream reset: a valid result, then rst with valid input clears outputs.
    set1(1'b1, 1'b1, 1'b0, 1'b0, 3'b001);
    set8(1'b1, 8'h0F, 8'h01, 1'b0, {1'b0, 1'b0, 8'h0E});
    cycle();
    rst = 1'b1;
    set1(1'b1, 1'b0, 1'b1, 1'b1, 3'b010);
    set8(1'b1, 8'h33, 8'h11, 1'b0, {1'b0, 1'b0, 8'h22});
    cycle();
    rst = 1'b0;
    set8(1'b1, 8'h01, 8'h02, 1'b0, {1'b0, 1'b1, 8'hFF});
    cycle();
    cycle();

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/full_subtractor.md
Name: full_subtractor

Overview:
- Registered full subtractor. Computes a − b − c, where c is the borrow-in. Outputs the difference d and the borrow-out bo.
- WIDTH=1 gives the classic 1-bit full subtractor cell. Wider instances form a ripple-borrow subtractor built from chained 1-bit cells.
- Used as an arithmetic leaf in datapaths. Outputs are registered, with a valid qualifier for pipelined use.

Parameters:
- WIDTH, 1, operand and difference width in bits (≥1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operands valid this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- c  input  1  borrow-in (subtracts 1 at the LSB).
- out_valid  output  1  d/bo hold a result computed from a valid input.
- d  output  WIDTH  difference, (a − b − c) mod 2^WIDTH.
- bo  output  1  borrow-out; 1 iff unsigned a < b + c.

Behaviour:
- One clock, synchronous active-high reset; the reset is sampled on the rising edge of clk only.
- Reset: d=0, bo=0, out_valid=0. Reset overrides in_valid in the same cycle. In-flight data is discarded.
- Per-bit cell i, with borrow chain br[0]=c:
  - d[i] = a[i] ^ b[i] ^ br[i]
  - br[i+1] = (~a[i] & b[i]) | (~a[i] & br[i]) | (b[i] & br[i])
  - bo = br[WIDTH]
- Equivalent arithmetic view: {bo,d} = {1'b0,a} − {1'b0,b} − c, taken modulo 2^(WIDTH+1).
- Latency: exactly 1 cycle. Inputs sampled at edge N with in_valid=1 → d/bo/out_valid=1 visible after edge N.
- When in_valid=0 at an edge:
  - out_valid is cleared to 0.
  - d and bo hold their previous values.
- No backpressure. A new result is accepted every cycle (throughput 1/cycle).
- Wrap-around: a=0, b=0, c=1 → d = all-ones, bo=1.
- Full borrow: a=0, b=all-ones, c=1 → d=0, bo=1.
- No X propagation on outputs after reset; all outputs are always driven from registers.

Optional Feature:
- Macro: FULL_SUBTRACTOR_OVF_EN.
- When defined:
  - Adds output ovf (1 bit, registered, same timing as d).
  - ovf = signed two's-complement overflow of a − b − c, i.e. br[WIDTH] ^ br[WIDTH−1].
  - For WIDTH=1 this is bo ^ c.
  - Reset value is 0; ovf holds its value when in_valid=0.
- When undefined: the ovf port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package full_subtractor_pkg:
  - localparam DEFAULT_WIDTH = 1.
  - Function fs_ref(a, b, c) returning {bo, d}, for use by the bench scoreboard.
- Sub-module fs_bit:
  - Purely combinational 1-bit cell: inputs a, b, bin; outputs d, bout.
  - Instantiated WIDTH times in a generate loop.
  - The top level holds only the borrow chain wiring and the output registers.

Test Plan:
- Reset: assert rst with in_valid=1, a=1, b=0, c=0 → d=0, bo=0, out_valid=0 after the edge; outputs stay 0 until rst is released.
- WIDTH=1 exhaustive, applying (a,b,c) = 000, 001, 010, 011, 100, 101, 110, 111 on consecutive valid cycles:
  - Expected (d,bo), 1 cycle later: 00, 11, 11, 01, 10, 00, 00, 11.
- WIDTH=8 wrap-around: a=0x00, b=0x00, c=1 → d=0xFF, bo=1. Then a=0x00, b=0xFF, c=1 → d=0x00, bo=1.
- WIDTH=8 normal and back-to-back:
  - a=0x50, b=0x20, c=0 → d=0x30, bo=0.
  - Next cycle a=0x20, b=0x50, c=0 → d=0xD0, bo=1.
  - out_valid stays high for both cycles.
- Hold behaviour: valid result, then in_valid=0 for 3 cycles with random a/b/c → out_valid=0, d/bo unchanged. Assert rst mid-stream → outputs cleared on that edge.
- With FULL_SUBTRACTOR_OVF_EN, WIDTH=8:
  - a=0x80, b=0x01, c=0 → d=0x7F, bo=0, ovf=1.
  - a=0x7F, b=0xFF, c=0 → d=0x80, bo=1, ovf=1.
  - a=0x10, b=0x01, c=0 → ovf=0.
